// File: rtl/axis_upsize_defines.sv
// Shared defines for the AXI-Stream width-conversion blocks.
`ifndef AXIS_UPSIZE_DEFINES_SV
`define AXIS_UPSIZE_DEFINES_SV
`define AXIS_RST_EDGE(rst) negedge rst
`endif

// File: rtl/axis_upsize.sv
// AXI-Stream upsizer: packs RATIO narrow beats into one wide beat, slot 0 in the LSBs.
// A short packet (tlast before the word is full) flushes early with upper slots zeroed.
`include "axis_upsize_defines.sv"

module axis_upsize #(
  parameter int S_DATA_WIDTH = 8,
  parameter int RATIO        = 4,
  parameter int USER_WIDTH   = 1,
  localparam int S_KEEP_WIDTH = S_DATA_WIDTH / 8,
  localparam int M_DATA_WIDTH = S_DATA_WIDTH * RATIO,
  localparam int M_KEEP_WIDTH = S_KEEP_WIDTH * RATIO
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    rstn_local,
  input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [USER_WIDTH-1:0]   m_axis_tuser
);

  localparam int IDX_W = $clog2(RATIO);

  logic [IDX_W-1:0]        idx;
  logic [S_DATA_WIDTH-1:0] acc_data [RATIO-1];
  logic [S_KEEP_WIDTH-1:0] acc_keep [RATIO-1];
  logic [USER_WIDTH-1:0]   acc_user;

  logic                    accept;
  logic                    complete;
  logic [M_DATA_WIDTH-1:0] word_data;
  logic [M_KEEP_WIDTH-1:0] word_keep;
  logic [USER_WIDTH-1:0]   word_user;

  // Ready depends only on the output register, so a held word back-pressures every beat.
  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign complete      = accept && (s_axis_tlast || (idx == IDX_W'(RATIO - 1)));

  always_comb begin
    word_data = '0;
    word_keep = '0;
    for (int i = 0; i < RATIO - 1; i++) begin
      if (i < int'(idx)) begin
        word_data[i*S_DATA_WIDTH +: S_DATA_WIDTH] = acc_data[i];
        word_keep[i*S_KEEP_WIDTH +: S_KEEP_WIDTH] = acc_keep[i];
      end
    end
    word_data[int'(idx)*S_DATA_WIDTH +: S_DATA_WIDTH] = s_axis_tdata;
    word_keep[int'(idx)*S_KEEP_WIDTH +: S_KEEP_WIDTH] = s_axis_tkeep;
    word_user = (idx == '0) ? s_axis_tuser : acc_user;
  end

  always_ff @(posedge clk or `AXIS_RST_EDGE(rstn)) begin
    if (!rstn) begin
      idx           <= '0;
      acc_user      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      for (int i = 0; i < RATIO - 1; i++) begin
        acc_data[i] <= '0;
        acc_keep[i] <= '0;
      end
    end else if (!rstn_local) begin
      idx           <= '0;
      m_axis_tvalid <= 1'b0;
    end else if (complete) begin
      // Loading a new word also covers the case where the old one is taken this cycle.
      m_axis_tdata  <= word_data;
      m_axis_tkeep  <= word_keep;
      m_axis_tuser  <= word_user;
      m_axis_tlast  <= s_axis_tlast;
      m_axis_tvalid <= 1'b1;
      idx           <= '0;
    end else begin
      if (accept) begin
        acc_data[idx] <= s_axis_tdata;
        acc_keep[idx] <= s_axis_tkeep;
        if (idx == '0) acc_user <= s_axis_tuser;
        idx <= idx + 1'b1;
      end
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_upsize.sv
// Directed bench for axis_upsize (8-bit in, RATIO=4): packing, short packets,
// back-pressure, streaming, local clear and a seeded random run against a model.
module tb_axis_upsize;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        rstn_local = 1'b1;
  logic [7:0]  s_data = '0;
  logic [0:0]  s_keep = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_last = 1'b0;
  logic [0:0]  s_user = '0;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic [0:0]  m_user;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [37:0] got_q[$];
  logic [37:0] exp_q[$];

  axis_upsize #(.S_DATA_WIDTH(8), .RATIO(4), .USER_WIDTH(1)) dut (
    .clk(clk), .rstn(rstn), .rstn_local(rstn_local),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
    .s_axis_tready(s_ready), .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_valid),
    .m_axis_tready(m_ready), .m_axis_tlast(m_last), .m_axis_tuser(m_user)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rstn && rstn_local && m_valid && m_ready)
      got_q.push_back({m_user, m_last, m_keep, m_data});
  end

  function automatic logic [37:0] wd(input logic u, input logic l, input logic [3:0] k,
                                     input logic [31:0] d);
    return {u, l, k, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [37:0] exp);
    logic [37:0] g;
    if (got_q.size() > 0) g = got_q.pop_front();
    else g = '1;
    chk(tag, {26'd0, g}, {26'd0, exp});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called one time unit after a rising edge; returns one time unit after the accepting edge.
  task automatic send_beat(input logic [7:0] d, input logic k, input logic l, input logic u);
    s_data = d; s_keep = k; s_last = l; s_user = u; s_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (s_ready) begin
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        return;
      end
      @(posedge clk);
    end
    s_valid = 1'b0;
    chk("send_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic        sr;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic [7:0]  md [4];
    logic        mk [4];
    logic        mu;
    int          mi;
    int          c0;
    int          c1;

    // Asynchronous reset
    #1 rstn = 1'b0;
    #1;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_keep", m_keep, 0);
    chk("rst_m_last_user", {m_last, m_user}, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    m_ready = 1'b1;

    // Full packet of four beats
    send_beat(8'h11, 1'b1, 1'b0, 1'b1);
    send_beat(8'h22, 1'b1, 1'b0, 1'b0);
    send_beat(8'h33, 1'b1, 1'b0, 1'b0);
    chk("full_no_early_valid", m_valid, 0);
    send_beat(8'h44, 1'b1, 1'b1, 1'b0);
    chk("full_valid_latency", m_valid, 1);
    chk("full_word", {m_user, m_last, m_keep, m_data}, wd(1'b1, 1'b1, 4'hF, 32'h44332211));

    // Short packet, then a full word to confirm the slot index restarted at 0
    send_beat(8'hAA, 1'b1, 1'b0, 1'b0);
    send_beat(8'hBB, 1'b1, 1'b1, 1'b0);
    chk("short_word", {m_user, m_last, m_keep, m_data}, wd(1'b0, 1'b1, 4'h3, 32'h0000BBAA));
    send_beat(8'h01, 1'b1, 1'b0, 1'b1);
    send_beat(8'h02, 1'b1, 1'b0, 1'b0);
    send_beat(8'h03, 1'b1, 1'b0, 1'b0);
    send_beat(8'h04, 1'b1, 1'b0, 1'b0);
    chk("idx_restart_word", {m_user, m_last, m_keep, m_data}, wd(1'b1, 1'b0, 4'hF, 32'h04030201));

    // Back-to-back single-beat packets: new word loads while the old one is taken
    idle(1);
    got_q.delete();
    send_beat(8'hC1, 1'b1, 1'b1, 1'b1);
    send_beat(8'hC2, 1'b1, 1'b1, 1'b0);
    chk("held_valid", m_valid, 1);
    idle(1);
    pop_chk("held_first", wd(1'b1, 1'b1, 4'h1, 32'h000000C1));
    pop_chk("held_second", wd(1'b0, 1'b1, 4'h1, 32'h000000C2));

    // Back-pressure: pending word blocks the next beat until downstream is ready
    got_q.delete();
    m_ready = 1'b0;
    send_beat(8'h10, 1'b1, 1'b0, 1'b1);
    send_beat(8'h11, 1'b1, 1'b0, 1'b0);
    send_beat(8'h12, 1'b1, 1'b0, 1'b0);
    send_beat(8'h13, 1'b1, 1'b0, 1'b0);
    s_data = 8'h20; s_keep = 1'b1; s_last = 1'b0; s_user = 1'b0; s_valid = 1'b1;
    #1;
    chk("bp_blocked", s_ready, 0);
    idle(3);
    chk("bp_still_blocked", s_ready, 0);
    chk("bp_stable", {m_valid, m_data}, {1'b1, 32'h13121110});
    m_ready = 1'b1;
    #1;
    chk("bp_released", s_ready, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    send_beat(8'h21, 1'b1, 1'b0, 1'b0);
    send_beat(8'h22, 1'b1, 1'b0, 1'b0);
    send_beat(8'h23, 1'b1, 1'b0, 1'b0);
    chk("bp_second_pending", {m_valid, m_data}, {1'b1, 32'h23222120});
    m_ready = 1'b1;
    idle(1);
    pop_chk("bp_word1", wd(1'b1, 1'b0, 4'hF, 32'h13121110));
    pop_chk("bp_word2", wd(1'b0, 1'b0, 4'hF, 32'h23222120));

    // Continuous stream of 64 bytes
    got_q.delete();
    c0 = cyc;
    for (int k = 0; k < 64; k++)
      send_beat(8'(k), 1'b1, k == 63, (k % 4 == 0) ? 1'((k / 4) % 2) : 1'(((k / 4) + 1) % 2));
    c1 = cyc;
    chk("stream_no_stall", c1 - c0, 64);
    idle(2);
    chk("stream_count", got_q.size(), 16);
    for (int w = 0; w < 16; w++)
      pop_chk("stream_word", wd(1'(w % 2), w == 15, 4'hF,
                                {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}));

    // Local clear discards a partial word
    send_beat(8'h50, 1'b1, 1'b0, 1'b0);
    send_beat(8'h51, 1'b1, 1'b0, 1'b0);
    rstn_local = 1'b0;
    idle(1);
    rstn_local = 1'b1;
    send_beat(8'h60, 1'b1, 1'b0, 1'b1);
    send_beat(8'h61, 1'b1, 1'b0, 1'b0);
    send_beat(8'h62, 1'b1, 1'b0, 1'b0);
    send_beat(8'h63, 1'b1, 1'b0, 1'b0);
    chk("clr_partial_word", {m_user, m_last, m_keep, m_data}, wd(1'b1, 1'b0, 4'hF, 32'h63626160));
    idle(1);

    // Local clear discards a pending output word
    m_ready = 1'b0;
    send_beat(8'h70, 1'b1, 1'b0, 1'b0);
    send_beat(8'h71, 1'b1, 1'b0, 1'b0);
    send_beat(8'h72, 1'b1, 1'b0, 1'b0);
    send_beat(8'h73, 1'b1, 1'b0, 1'b0);
    chk("clr_pending_before", m_valid, 1);
    rstn_local = 1'b0;
    idle(1);
    chk("clr_pending_after", {m_valid, s_ready}, 2'b01);
    rstn_local = 1'b1;

    // Seeded random traffic against a packing model
    void'($urandom(32'h1234_5678));
    got_q.delete();
    exp_q.delete();
    mi = 0;
    mu = 1'b0;
    s_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!s_valid) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_data  = 8'($urandom);
        s_keep  = 1'($urandom);
        s_last  = ($urandom_range(0, 5) == 0);
        s_user  = 1'($urandom);
      end
      m_ready = ($urandom_range(0, 2) != 0);
      #1;
      sr = s_ready;
      chk("rand_sready", sr, !m_valid || m_ready);
      s_valid = !s_valid;
      #1;
      chk("rand_sready_indep", s_ready, sr);
      s_valid = !s_valid;
      if (s_valid && sr) begin
        md[mi] = s_data;
        mk[mi] = s_keep;
        if (mi == 0) mu = s_user;
        if (mi == 3 || s_last) begin
          ed = '0;
          ek = '0;
          for (int j = 0; j <= mi; j++) begin
            ed[j*8 +: 8] = md[j];
            ek[j] = mk[j];
          end
          exp_q.push_back(wd(mu, s_last, ek, ed));
          mi = 0;
        end else begin
          mi++;
        end
      end
      @(posedge clk); #1;
      if (s_valid && sr) s_valid = 1'b0;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    idle(3);
    chk("rand_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0) pop_chk("rand_word", exp_q.pop_front());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
